// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch stage.
// Keeps the PC, fetches one instruction per memory handshake and picks the
// next PC from the sequential, branch, jump and jump-register sources.
//
// state | meaning
// ------+-------------------------------------------------------------------
// FETCH | imem_req high at pc; waiting for imem_ack to capture the word
// VALID | inst/pc_out hold a fetched instruction until downstream takes it
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset_sl2,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        addr_err
);

    typedef enum logic {
        FETCH = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        jr_misaligned;

    // Request and address come straight from registered state and pc.
    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign pc_out    = pc;
    assign pc_plus4  = pc + 32'd4;

    assign jr_misaligned = (jr_target[1:0] != 2'b00);

    // Next-PC selection; JR beats J, J beats a taken branch.
    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = {jr_target[31:2], 2'b00};
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + branch_offset_sl2;
        end
    end

    // Fetch/hold FSM; redirects and the sticky JR alignment error are taken
    // only when the held instruction is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            inst_valid <= 1'b0;
            inst       <= 32'h0000_0000;
            addr_err   <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        inst       <= imem_rdata;
                        inst_valid <= 1'b1;
                        state      <= VALID;
                    end
                end
                VALID: begin
                    if (!stall) begin
                        pc         <= next_pc;
                        inst_valid <= 1'b0;
                        state      <= FETCH;
                        if (jr && jr_misaligned) begin
                            addr_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and instruction-fetch stage of the single-issue MIPS-style CPU. It holds the PC and fetches one instruction per handshake from instruction memory. It computes the next PC from sequential, branch, jump and jump-register sources. It consumes the word-aligned branch offset produced by the left-shift-by-2 stage (sign-extended immediate << 2) and adds it to PC+4 to form the branch target.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  rising-edge clock, sole clock domain
- rst  in  1  synchronous, active-high reset
- stall  in  1  downstream not ready; holds the current instruction
- branch_taken  in  1  conditional branch resolved taken for the presented instruction
- branch_offset_sl2  in  32  sign-extended offset already shifted left 2
- jump  in  1  J/JAL for the presented instruction
- jump_index  in  26  instr[25:0] of the jump
- jr  in  1  JR/JALR for the presented instruction
- jr_target  in  32  register value for JR
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_ack  in  1  memory returns data this cycle
- imem_rdata  in  32  instruction word, valid with imem_ack
- inst_valid  out  1  inst/pc_out hold a fetched instruction
- inst  out  32  fetched instruction
- pc_out  out  32  address of inst
- pc_plus4  out  32  pc_out + 4 (mod 2^32), for link writes
- addr_err  out  1  sticky: misaligned JR target seen

## Operation
- Reset values: pc=RESET_PC, state=FETCH, inst_valid=0, inst=0, addr_err=0. imem_req=1 from the first cycle after reset deasserts.
- FSM has two states, FETCH and VALID.
- FETCH: imem_req=1, imem_addr=pc. When imem_ack=1, register inst<=imem_rdata and inst_valid<=1, then go to VALID. If imem_ack=0, stay in FETCH with req and addr held stable.
- VALID: imem_req=0 and inst_valid=1.
  - stall=1: hold all state, with inst, pc_out and inst_valid unchanged.
  - stall=0: pc<=next_pc, inst_valid<=0, go to FETCH.
- next_pc priority, sampled only in VALID with stall=0:
  - jr: {jr_target[31:2],2'b00}. If jr_target[1:0]!=0, addr_err<=1; the sticky flag is cleared only by rst.
  - else jump: {pc_plus4[31:28], jump_index, 2'b00}.
  - else branch_taken: pc_plus4 + branch_offset_sl2, 32-bit wrap, no overflow flag.
  - else pc_plus4.
- Redirect inputs are ignored outside VALID&&!stall. Multiple asserted inputs are resolved by priority, with no error raised.
- imem_ack outside FETCH is ignored, and imem_rdata is ignored unless FETCH&&imem_ack.
- pc_plus4 = pc+4 combinational; 32'hFFFF_FFFC wraps to 0.
- No delay slot: the branch target is the next fetch.

## Timing
- imem_req and imem_addr are decoded from registered state and pc, so they are glitch-free at the clock edge.
- Same-cycle ack is allowed. The minimum is 2 cycles per instruction (FETCH+ack, then VALID).
- inst_valid rises the cycle after the accepting ack edge. The first fetch address after reset is RESET_PC.
- The redirect takes effect at the edge ending VALID&&!stall. imem_addr shows the new PC in the very next cycle.
- rst mid-fetch: at the next edge the in-flight fetch is abandoned. A late imem_ack from the abandoned fetch arrives in the reset FETCH and is accepted as RESET_PC data. The memory must not ack after losing req, which is a system rule.
- rst in VALID: inst_valid=0 after the edge. Redirects in that cycle are discarded.

## Test plan
- Reset then sequential fetch: memory always acks with data=addr. Required: fetch addrs 0,4,8,C; inst_valid high every other cycle; pc_plus4 = pc_out+4.
- Taken branch at pc=0x100 with branch_offset_sl2=0xFFFFFFF0. Required: next imem_addr=0x0F4. Repeat with 0x40, required next imem_addr=0x144.
- Jump at pc=0xA000_0010 with jump_index=0x0000040. Required: next imem_addr=0xA000_0100. Then jr=1, jump=1, branch_taken=1 together with jr_target=0x2000. Required: next imem_addr=0x2000, since JR wins.
- Stall for 5 cycles in VALID while redirect inputs toggle. Required: inst, pc_out and inst_valid constant; no new req; only the redirect values present on the cycle stall drops are used.
- imem_ack delayed 3 cycles. Required: imem_req and imem_addr stable throughout and inst_valid=0. A spurious ack in VALID is ignored.
- JR to 0x1003. Required: addr_err=1, fetch addr 0x1000, flag sticky until rst. Also assert rst during FETCH. Required: next cycle fetch addr=RESET_PC and inst_valid=0.
